cycle_terminate: RTL and testbench

Bus-cycle termination stage directly downstream of the local address decoder on the computie-vme k30p board. Consumes the active-low per-target request strobes and the CPU strobes. Counts per-target wait states and drives the 68030 asynchronous termination signals: DSACK1/DSACK0, with port size encoded, and BERR. Also watchdogs every cycle, so an unmapped or hung access ends in a bus error rather than a lock-up.

---
 rtl/k30p_bus_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 39 +++
 rtl/cycle_terminate.sv | 159 +++++++++++++++
 tb/tb_cycle_terminate.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k30p_bus_pkg.sv
// Shared encodings for the k30p local bus: DSACK port-size codes, strobe levels and
// the cycle-termination state encoding.
package k30p_bus_pkg;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StVme,
        StAck,
        StErr
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating per-cycle watchdog. expired_pulse flags the edge on which the count
// reaches TIMEOUT_CYCLES; expired stays high once it has got there.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clear,
    input  logic run,
    output logic expired,
    output logic expired_pulse
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] Limit = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired       = (count_q == Limit);
    assign expired_pulse = run && !clear && (count_q == Limit - 1'b1);

endmodule

// File: rtl/cycle_terminate.sv
// 68030 bus-cycle termination: per-target wait states, VME handshake pass-through and
// watchdog bus error, all driven onto registered DSACK/BERR.
module cycle_terminate
    import k30p_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT       = 1,
    parameter int unsigned ROM_WAIT       = 3,
    parameter int unsigned SERIAL_WAIT    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cpu_as,
    input  logic       request_ram,
    input  logic       request_rom,
    input  logic       request_serial,
    input  logic       request_vme_a16,
    input  logic       request_vme_a24,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       timeout
);

    localparam int unsigned MaxWait = max3(RAM_WAIT, ROM_WAIT, SERIAL_WAIT);
    localparam int unsigned WW      = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          mapped_q, mapped_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    dsack_q, dsack_d;
    logic          berr_q, berr_d;
    logic          timeout_q, timeout_d;

    logic wd_clear, wd_run, wd_expired, wd_pulse, wd_fire;

    assign wd_clear = (state_q == StIdle);
    assign wd_run   = (state_q == StWait) || (state_q == StVme);
    assign wd_fire  = wd_pulse || wd_expired;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock        (clock),
        .n_reset      (n_reset),
        .clear        (wd_clear),
        .run          (wd_run),
        .expired      (wd_expired),
        .expired_pulse(wd_pulse)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mapped_d  = mapped_q;
        size_d    = size_q;
        dsack_d   = DSACK_NONE;
        berr_d    = INACTIVE;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_as == ACTIVE) begin
                    state_d  = StWait;
                    mapped_d = 1'b1;
                    wait_d   = '0;
                    if (request_ram == ACTIVE) begin
                        wait_d = WW'(RAM_WAIT);
                        size_d = DSACK_32;
                    end else if (request_rom == ACTIVE) begin
                        wait_d = WW'(ROM_WAIT);
                        size_d = DSACK_16;
                    end else if (request_serial == ACTIVE) begin
                        wait_d = WW'(SERIAL_WAIT);
                        size_d = DSACK_8;
                    end else if ((request_vme_a16 == ACTIVE) || (request_vme_a24 == ACTIVE)) begin
                        state_d  = StVme;
                        mapped_d = 1'b0;
                        size_d   = DSACK_32;
                    end else begin
                        // Unmapped: wait counter never terminates, only the watchdog can.
                        mapped_d = 1'b0;
                        size_d   = DSACK_NONE;
                    end
                end
            end
            StWait: begin
                if (cpu_as == INACTIVE) begin
                    state_d = StIdle;
                end else if (mapped_q && (wait_q == '0)) begin
                    state_d = StAck;
                    dsack_d = size_q;
                end else if (wd_fire) begin
                    state_d   = StErr;
                    berr_d    = ACTIVE;
                    timeout_d = 1'b1;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StVme: begin
                if (cpu_as == INACTIVE) begin
                    state_d = StIdle;
                end else if (vme_berr == ACTIVE) begin
                    state_d = StErr;
                    berr_d  = ACTIVE;
                end else if (vme_dtack == ACTIVE) begin
                    state_d = StAck;
                    dsack_d = DSACK_32;
                end else if (wd_fire) begin
                    state_d   = StErr;
                    berr_d    = ACTIVE;
                    timeout_d = 1'b1;
                end
            end
            StAck: begin
                if (cpu_as == INACTIVE) begin
                    state_d = StIdle;
                end else begin
                    dsack_d = dsack_q;
                end
            end
            StErr: begin
                if (cpu_as == INACTIVE) begin
                    state_d = StIdle;
                end else begin
                    berr_d = berr_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            mapped_q  <= 1'b0;
            size_q    <= DSACK_NONE;
            dsack_q   <= DSACK_NONE;
            berr_q    <= INACTIVE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mapped_q  <= mapped_d;
            size_q    <= size_d;
            dsack_q   <= dsack_d;
            berr_q    <= berr_d;
            timeout_q <= timeout_d;
        end
    end

    assign cpu_dsack = dsack_q;
    assign cpu_berr  = berr_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cycle_terminate.sv
// Directed bench for cycle_terminate with TIMEOUT_CYCLES shortened to 16.
module tb_cycle_terminate;
    import k30p_bus_pkg::*;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       cpu_as;
    logic       request_ram, request_rom, request_serial;
    logic       request_vme_a16, request_vme_a24;
    logic       vme_dtack, vme_berr;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    cycle_terminate #(
        .RAM_WAIT      (1),
        .ROM_WAIT      (3),
        .SERIAL_WAIT   (4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock          (clock),
        .n_reset        (n_reset),
        .cpu_as         (cpu_as),
        .request_ram    (request_ram),
        .request_rom    (request_rom),
        .request_serial (request_serial),
        .request_vme_a16(request_vme_a16),
        .request_vme_a24(request_vme_a24),
        .vme_dtack      (vme_dtack),
        .vme_berr       (vme_berr),
        .cpu_dsack      (cpu_dsack),
        .cpu_berr       (cpu_berr),
        .timeout        (timeout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        cpu_as          = 1'b1;
        request_ram     = 1'b1;
        request_rom     = 1'b1;
        request_serial  = 1'b1;
        request_vme_a16 = 1'b1;
        request_vme_a24 = 1'b1;
        vme_dtack       = 1'b1;
        vme_berr        = 1'b1;
    endtask

    // sel: 0 ram, 1 rom, 2 serial. hold = clocks with AS low, must exceed 1+w.
    task automatic run_local(input string name, input int sel, input int w,
                             input logic [1:0] code, input int hold);
        logic [1:0] exp;
        cpu_as = 1'b0;
        if (sel == 0) request_ram = 1'b0;
        if (sel == 1) request_rom = 1'b0;
        if (sel == 2) request_serial = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            exp = (k >= 1 + w) ? code : 2'b11;
            total++;
            if (cpu_dsack !== exp || cpu_berr !== 1'b1) begin
                bad++;
                $display("FAIL %s edge n+%0d: dsack=%b berr=%b required dsack=%b berr=1",
                         name, k, cpu_dsack, cpu_berr, exp);
            end
        end
        bus_idle();
        tick();
        total++;
        if (cpu_dsack !== 2'b11 || cpu_berr !== 1'b1 || dut.state_q !== StIdle) begin
            bad++;
            $display("FAIL %s release: dsack=%b berr=%b state=%0d required 11/1/idle",
                     name, cpu_dsack, cpu_berr, dut.state_q);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        n_reset = 1'b0;
        tick();
        tick();
        total++;
        if (cpu_dsack !== 2'b11 || cpu_berr !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset: dsack=%b berr=%b timeout=%b required 11/1/0",
                     cpu_dsack, cpu_berr, timeout);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_ram();
        run_local("ram", 0, 1, 2'b00, 6);
    endtask

    task automatic test_priority();
        request_serial = 1'b0;
        request_rom    = 1'b0;
        run_local("prio_ram", 0, 1, 2'b00, 4);
    endtask

    task automatic test_back_to_back();
        run_local("b2b_serial", 2, 4, 2'b10, 7);
        run_local("b2b_rom", 1, 3, 2'b01, 6);
    endtask

    task automatic test_unmapped();
        logic exp_berr, exp_to;
        cpu_as = 1'b0;
        for (int k = 0; k < T + 4; k++) begin
            tick();
            exp_berr = (k >= T) ? 1'b0 : 1'b1;
            exp_to   = (k == T) ? 1'b1 : 1'b0;
            total++;
            if (cpu_berr !== exp_berr || timeout !== exp_to || cpu_dsack !== 2'b11) begin
                bad++;
                $display("FAIL unmapped edge n+%0d: berr=%b timeout=%b dsack=%b required %b/%b/11",
                         k, cpu_berr, timeout, cpu_dsack, exp_berr, exp_to);
            end
        end
        bus_idle();
        tick();
        total++;
        if (cpu_berr !== 1'b1 || timeout !== 1'b0 || dut.state_q !== StIdle) begin
            bad++;
            $display("FAIL unmapped release: berr=%b timeout=%b required 1/0 and idle",
                     cpu_berr, timeout);
        end
    endtask

    task automatic test_vme_berr_wins();
        cpu_as          = 1'b0;
        request_vme_a24 = 1'b0;
        tick();
        vme_dtack = 1'b0;
        vme_berr  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (cpu_berr !== 1'b0 || cpu_dsack !== 2'b11 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL vme_both hold %0d: berr=%b dsack=%b timeout=%b required 0/11/0",
                         k, cpu_berr, cpu_dsack, timeout);
            end
        end
        bus_idle();
        tick();
        total++;
        if (cpu_berr !== 1'b1 || cpu_dsack !== 2'b11) begin
            bad++;
            $display("FAIL vme_both release: berr=%b dsack=%b required 1/11", cpu_berr, cpu_dsack);
        end
    endtask

    task automatic test_vme_dtack();
        logic [1:0] exp;
        cpu_as          = 1'b0;
        request_vme_a24 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp = (k >= 6) ? 2'b00 : 2'b11;
            total++;
            if (cpu_dsack !== exp || cpu_berr !== 1'b1) begin
                bad++;
                $display("FAIL vme_dtack edge n+%0d: dsack=%b berr=%b required %b/1",
                         k, cpu_dsack, cpu_berr, exp);
            end
            if (k == 5) vme_dtack = 1'b0;
        end
        bus_idle();
        tick();
        total++;
        if (cpu_dsack !== 2'b11 || dut.state_q !== StIdle) begin
            bad++;
            $display("FAIL vme_dtack release: dsack=%b required 11 and idle", cpu_dsack);
        end
    endtask

    task automatic test_abort();
        cpu_as      = 1'b0;
        request_rom = 1'b0;
        tick();
        tick();
        bus_idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (cpu_dsack !== 2'b11 || cpu_berr !== 1'b1 || dut.state_q !== StIdle) begin
                bad++;
                $display("FAIL abort %0d: dsack=%b berr=%b state=%0d required 11/1/idle",
                         k, cpu_dsack, cpu_berr, dut.state_q);
            end
        end
        run_local("after_abort_ram", 0, 1, 2'b00, 4);
    endtask

    task automatic test_reset_in_ack();
        cpu_as      = 1'b0;
        request_ram = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (cpu_dsack !== 2'b00) begin
            bad++;
            $display("FAIL rst_ack pre: dsack=%b required 00", cpu_dsack);
        end
        n_reset = 1'b0;
        tick();
        total++;
        if (cpu_dsack !== 2'b11 || cpu_berr !== 1'b1 || dut.state_q !== StIdle) begin
            bad++;
            $display("FAIL rst_ack: dsack=%b berr=%b state=%0d required 11/1/idle",
                     cpu_dsack, cpu_berr, dut.state_q);
        end
        n_reset = 1'b1;
        bus_idle();
        tick();
        run_local("after_reset_ram", 0, 1, 2'b00, 4);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_priority();
        test_back_to_back();
        test_unmapped();
        test_vme_berr_wins();
        test_vme_dtack();
        test_abort();
        test_reset_in_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
